gp_cmd_arbiter: RTL and testbench

//  Multi-client front end for graphics_processor: NUM_CH producers (game_controller, score/UI painters, ...)

---
 rtl/gp_cmd_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_gp_cmd_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_cmd_arbiter.sv
// Multi-channel draw-command front end: per-channel FIFOs and a round-robin issuer on the gp_en/gp_finish handshake.
// Optional WAIT-state watchdog enabled by defining GP_ARB_TIMEOUT_EN.
module gp_cmd_arbiter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned OP_W        = 1,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 9,
    parameter int unsigned ARG_W       = 12,
    parameter int unsigned TIMEOUT_CYC = 65535,
    localparam int unsigned CMD_W      = OP_W + 2 * X_W + 2 * Y_W + ARG_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         cmd_valid,
    output logic [NUM_CH-1:0]         cmd_ready,
    input  logic [NUM_CH*CMD_W-1:0]   cmd_data,
    output logic [NUM_CH-1:0]         cmd_done,
    output logic                      gp_en,
    output logic [OP_W-1:0]           gp_opcode,
    output logic [X_W-1:0]            gp_tl_x,
    output logic [Y_W-1:0]            gp_tl_y,
    output logic [X_W-1:0]            gp_br_x,
    output logic [Y_W-1:0]            gp_br_y,
    output logic [ARG_W-1:0]          gp_arg,
    input  logic                      gp_finish,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [X_W-1:0]   tl_x;
        logic [Y_W-1:0]   tl_y;
        logic [X_W-1:0]   br_x;
        logic [Y_W-1:0]   br_y;
        logic [ARG_W-1:0] arg;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    cmd_t                gp_cmd_q, gp_cmd_d;
    logic                gp_en_q, gp_en_d;
    logic [NUM_CH-1:0]   cmd_done_q, cmd_done_d;
    logic [NUM_CH-1:0]   cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]    wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]    rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]    rd_ptr_d [NUM_CH];
    logic [CMD_W-1:0]    mem_q    [NUM_CH][DEPTH];

    logic [NUM_CH-1:0]   push;
    logic [NUM_CH-1:0]   pop;
    logic [NUM_CH-1:0]   nonempty;
    logic                any_ne_d;
    logic                found;
    logic [CH_W-1:0]     gnt;
    logic [CH_W-1:0]     cand;
    cmd_t                head;

`ifdef GP_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 16) ? $clog2(TIMEOUT_CYC + 1) : 16;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                timeout_err_q, timeout_err_d;
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Arbitration, FSM next state, FIFO pointer and status updates.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        gp_cmd_d    = gp_cmd_q;
        gp_en_d     = 1'b0;
        cmd_done_d  = '0;
        cmd_ready_d = cmd_ready_q;
        push        = cmd_valid & cmd_ready_q;
        pop         = '0;
        found       = 1'b0;
        gnt         = '0;
        cand        = '0;
        any_ne_d    = 1'b0;
`ifdef GP_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = 1'b0;
`endif

        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (wr_ptr_q[i] != rd_ptr_q[i]);
        end

        // First non-empty channel at or after the round-robin pointer.
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (!found && nonempty[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
        head = cmd_t'(mem_q[gnt][rd_ptr_q[gnt][AW-1:0]]);

        case (state_q)
            IDLE: begin
                if (found) begin
                    pop[gnt] = 1'b1;
                    gp_cmd_d = head;
                    grant_d  = gnt;
                    rr_d     = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
                    gp_en_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef GP_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (gp_finish) begin
                    cmd_done_d[grant_q] = 1'b1;
                    state_d             = IDLE;
                end
`ifdef GP_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    cmd_done_d[grant_q] = 1'b1;
                    timeout_err_d       = 1'b1;
                    state_d             = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_d[i]    = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i]    = rd_ptr_q[i] + PTR_W'(pop[i]);
            cmd_ready_d[i] = ((wr_ptr_d[i] - rd_ptr_d[i]) != PTR_W'(DEPTH));
            if (wr_ptr_d[i] != rd_ptr_d[i]) begin
                any_ne_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE) || any_ne_d;
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            gp_cmd_q    <= '0;
            gp_en_q     <= 1'b0;
            cmd_done_q  <= '0;
            cmd_ready_q <= '1;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
`ifdef GP_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            gp_cmd_q    <= gp_cmd_d;
            gp_en_q     <= gp_en_d;
            cmd_done_q  <= cmd_done_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef GP_ARB_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= cmd_data[i*CMD_W +: CMD_W];
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_done  = cmd_done_q;
    assign gp_en     = gp_en_q;
    assign gp_opcode = gp_cmd_q.opcode;
    assign gp_tl_x   = gp_cmd_q.tl_x;
    assign gp_tl_y   = gp_cmd_q.tl_y;
    assign gp_br_x   = gp_cmd_q.br_x;
    assign gp_br_y   = gp_cmd_q.br_y;
    assign gp_arg    = gp_cmd_q.arg;
    assign busy      = busy_q;
`ifdef GP_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_gp_cmd_arbiter.sv
// Scoreboard bench for gp_cmd_arbiter: directed stimulus queues expected issues/completions, a monitor checks them.
module tb_gp_cmd_arbiter;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned OP_W   = 1;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned ARG_W  = 12;
    localparam int unsigned TO_CYC = 16;
    localparam int unsigned CMD_W  = OP_W + 2 * X_W + 2 * Y_W + ARG_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       cmd_valid;
    logic [NUM_CH-1:0]       cmd_ready;
    logic [NUM_CH*CMD_W-1:0] cmd_data;
    logic [NUM_CH-1:0]       cmd_done;
    logic                    gp_en;
    logic [OP_W-1:0]         gp_opcode;
    logic [X_W-1:0]          gp_tl_x;
    logic [Y_W-1:0]          gp_tl_y;
    logic [X_W-1:0]          gp_br_x;
    logic [Y_W-1:0]          gp_br_y;
    logic [ARG_W-1:0]        gp_arg;
    logic                    gp_finish;
    logic                    busy;
    logic                    timeout_err;

    logic fin_auto, fin_man, auto_fin;
    assign gp_finish = fin_auto | fin_man;

    gp_cmd_arbiter #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .OP_W(OP_W), .X_W(X_W), .Y_W(Y_W),
        .ARG_W(ARG_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_done(cmd_done), .gp_en(gp_en),
        .gp_opcode(gp_opcode), .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y),
        .gp_br_x(gp_br_x), .gp_br_y(gp_br_y), .gp_arg(gp_arg),
        .gp_finish(gp_finish), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [CMD_W-1:0] cmd; int t; } iss_t;
    typedef struct { logic [NUM_CH-1:0] done; logic to; int t; } done_t;
    iss_t  iss_q[$];
    done_t done_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk(input logic [OP_W-1:0] op, input logic [X_W-1:0] tlx,
                                           input logic [Y_W-1:0] tly, input logic [X_W-1:0] brx,
                                           input logic [Y_W-1:0] bry, input logic [ARG_W-1:0] arg);
        return {op, tlx, tly, brx, bry, arg};
    endfunction

    function automatic logic [CMD_W-1:0] mkn(input int n);
        return mk(OP_W'(n & 1), X_W'(n * 3), Y_W'(n * 5), X_W'(n * 7 + 1), Y_W'(n * 11 + 2), ARG_W'(n * 13 + 3));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every issue strobe and completion pulse must match the head of its queue.
    always @(negedge clk) begin
        iss_t  ei;
        done_t ed;
        if (rst === 1'b0) begin
            if (gp_en === 1'b1) begin
                if (iss_q.size() == 0) begin
                    check("unexpected_gp_en", 64'(gp_en), 64'd0);
                end else begin
                    ei = iss_q.pop_front();
                    check("issue_fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'(ei.cmd));
                    if (ei.t >= 0) check("issue_cycle", 64'(cyc), 64'(ei.t));
                end
            end
            if (cmd_done !== '0 || timeout_err !== 1'b0) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'({cmd_done, timeout_err}), 64'd0);
                end else begin
                    ed = done_q.pop_front();
                    check("done_vec", 64'(cmd_done), 64'(ed.done));
                    check("timeout_err", 64'(timeout_err), 64'(ed.to));
                    if (ed.t >= 0) check("done_cycle", 64'(cyc), 64'(ed.t));
                end
            end
        end
    end

    // Graphics processor model: finish a fixed number of cycles after each issue when enabled.
    initial begin
        fin_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (gp_en === 1'b1 && auto_fin) begin
                repeat (3) @(posedge clk);
                #1 fin_auto = 1'b1;
                @(posedge clk);
                #1 fin_auto = 1'b0;
            end
        end
    end

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((iss_q.size() != 0 || done_q.size() != 0) && n < limit) begin
            tick;
            n++;
        end
        check(name, 64'(iss_q.size() + done_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick;
        rst = 1'b0;
    endtask

    initial begin
        int w;
        bit seen;
        logic [CMD_W-1:0] c;
        cmd_valid = '0;
        cmd_data  = '0;
        fin_man   = 1'b0;
        auto_fin  = 1'b0;

        // Reset values
        do_reset(3);
        @(negedge clk);
        check("rst_gp_en", 64'(gp_en), 64'd0);
        check("rst_fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd3);
        check("rst_cmd_done", 64'(cmd_done), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);

        // Single command latency and field hold
        tick;
        w = cyc;
        c = mk(1'b1, 10'd10, 9'd20, 10'd30, 9'd40, 12'hF00);
        iss_q.push_back('{cmd: c, t: w + 2});
        done_q.push_back('{done: 2'b01, to: 1'b0, t: w + 7});
        cmd_valid[0] = 1'b1;
        cmd_data[0 +: CMD_W] = c;
        tick;
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        check("t2_busy_queued", 64'(busy), 64'd1);
        while (cyc < w + 6) tick;
        fin_man = 1'b1;
        tick;
        fin_man = 1'b0;
        tick;
        @(negedge clk);
        check("t2_hold_fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'(c));
        check("t2_busy_idle", 64'(busy), 64'd0);
        drain("t2_drain", 20);

        // Round robin over two channels, two commands each
        do_reset(2);
        auto_fin = 1'b1;
        w = cyc;
        for (int k = 0; k < 4; k++) begin
            iss_q.push_back('{cmd: mkn(k + 1), t: w + 2 + 5 * k});
            done_q.push_back('{done: (k % 2 == 0) ? 2'b01 : 2'b10, to: 1'b0, t: w + 6 + 5 * k});
        end
        cmd_valid = 2'b11;
        cmd_data  = {mkn(2), mkn(1)};
        tick;
        cmd_data  = {mkn(4), mkn(3)};
        tick;
        cmd_valid = '0;
        drain("t3_drain", 100);

        // Backpressure on a full FIFO while the processor is stalled
        auto_fin = 1'b0;
        tick;
        w = cyc;
        iss_q.push_back('{cmd: mkn(10), t: w + 2});
        done_q.push_back('{done: 2'b01, to: 1'b0, t: -1});
        for (int k = 0; k < 5; k++) begin
            iss_q.push_back('{cmd: mkn(20 + k), t: -1});
            done_q.push_back('{done: 2'b10, to: 1'b0, t: -1});
        end
        cmd_valid[0] = 1'b1;
        cmd_data[0 +: CMD_W] = mkn(10);
        tick;
        cmd_valid[0] = 1'b0;
        repeat (3) tick;
        for (int k = 0; k < 4; k++) begin
            cmd_valid[1] = 1'b1;
            cmd_data[CMD_W +: CMD_W] = mkn(20 + k);
            @(negedge clk);
            check("t4_ready_open", 64'(cmd_ready[1]), 64'd1);
            tick;
        end
        cmd_data[CMD_W +: CMD_W] = mkn(24);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_ready_full", 64'(cmd_ready[1]), 64'd0);
            tick;
        end
        fin_man = 1'b1;
        tick;
        fin_man  = 1'b0;
        auto_fin = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (cmd_ready[1] === 1'b1) seen = 1'b1;
            tick;
        end
        cmd_valid[1] = 1'b0;
        check("t4_ready_back", 64'(seen), 64'd1);
        drain("t4_drain", 150);

        // Stray finish in IDLE, then reset while a command is outstanding
        auto_fin = 1'b0;
        tick;
        fin_man = 1'b1;
        tick;
        fin_man = 1'b0;
        repeat (2) tick;
        @(negedge clk);
        check("t5_idle_busy", 64'(busy), 64'd0);
        iss_q.push_back('{cmd: mkn(30), t: cyc + 2});
        cmd_valid[0] = 1'b1;
        cmd_data[0 +: CMD_W] = mkn(30);
        tick;
        cmd_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid[1] = 1'b1;
            cmd_data[CMD_W +: CMD_W] = mkn(31 + k);
            tick;
        end
        cmd_valid[1] = 1'b0;
        tick;
        @(negedge clk);
        check("t5_busy_wait", 64'(busy), 64'd1);
        check("t5_issued", 64'(iss_q.size()), 64'd0);
        do_reset(2);
        @(negedge clk);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_ready", 64'(cmd_ready), 64'd3);
        check("t5_rst_fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'd0);
        fin_man = 1'b1;
        tick;
        fin_man = 1'b0;
        repeat (10) tick;
        @(negedge clk);
        check("t5_still_idle", 64'({busy, cmd_done, gp_en}), 64'd0);

`ifdef GP_ARB_TIMEOUT_EN
        // Watchdog expiry and recovery
        tick;
        w = cyc;
        iss_q.push_back('{cmd: mkn(40), t: w + 2});
        done_q.push_back('{done: 2'b01, to: 1'b1, t: w + 19});
        iss_q.push_back('{cmd: mkn(41), t: w + 20});
        done_q.push_back('{done: 2'b01, to: 1'b1, t: w + 37});
        cmd_valid[0] = 1'b1;
        cmd_data[0 +: CMD_W] = mkn(40);
        tick;
        cmd_data[0 +: CMD_W] = mkn(41);
        tick;
        cmd_valid[0] = 1'b0;
        drain("t6_drain", 80);
`endif

        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
